// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receiver.
//   rx_state_t     FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4)
//   clks_per_bit   clock cycles per bit, integer division of clock by baud
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_shift.sv
// uart_rx_shift: 8-bit right-shift register, serial input enters at the MSB
// so that an LSB-first byte is fully aligned after eight shifts.
//   clk       system clock
//   rst_n     synchronous, active-low reset (clears the register)
//   shift_en  shift one position this cycle
//   sin       serial input bit
//   dout      parallel contents
module uart_rx_shift (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       shift_en,
   input  logic       sin,
   output logic [7:0] dout
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (shift_en) begin
         dout <= {sin, dout[7:1]};
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
//   clk        system clock
//   rst_n      synchronous, active-low reset
//   rx_i       asynchronous serial line, idle high
//   rx_data    last good byte, held until the next good byte
//   rx_valid   1-cycle pulse, rx_data updated this cycle
//   frame_err  1-cycle pulse, stop bit sampled low
//   busy       high whenever the receiver is not idle
// CLKS_PER_BIT = CLK_FREQ/BAUD must be at least 4.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_t        state_q, state_d;
   logic             rx_meta, rx_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic             shift_en, valid_set, ferr_set;
   logic [7:0]       shreg;

   uart_rx_shift u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .sin      (rx_s),
      .dout     (shreg)
   );

   // State register together with synchroniser, timing counters and the
   // registered output pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_meta   <= rx_i;
         rx_s      <= rx_meta;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         rx_valid  <= valid_set;
         frame_err <= ferr_set;
         if (valid_set) begin
            rx_data <= shreg;
         end
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      bit_idx_d = bit_idx_q;
      shift_en  = 1'b0;
      valid_set = 1'b0;
      ferr_set  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = START;
            end
         end
         START: begin
            // Half a bit into the start bit: a high line means it was a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d    = '0;
               shift_en = 1'b1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         STOP: begin
            // Leaving at mid stop bit leaves half a bit to catch the next start edge.
            if (cnt_q == FULL_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  valid_set = 1'b1;
                  state_d   = IDLE;
               end else begin
                  ferr_set = 1'b1;
                  state_d  = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Moore outputs.
   always_comb begin
      busy = (state_q != IDLE);
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx at CLKS_PER_BIT=10.
// Frames are driven with time-based bit periods; each frame queues its expected
// outcome (good byte or framing error) and a monitor matches every output pulse.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_i = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   typedef struct {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  last_good = 8'h00;
   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   uart_rx #(
      .CLK_FREQ (1_000_000),
      .BAUD     (100_000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_i      (rx_i),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5ns clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one 8N1 frame, LSB first; bit_ns is the bit period in ns (nominal 100).
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int unsigned bit_ns);
      exp_t e;
      e.is_err = !stop_bit;
      e.data   = b;
      exp_q.push_back(e);
      rx_i = 1'b0;
      #(bit_ns * 1ns);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         #(bit_ns * 1ns);
      end
      rx_i = stop_bit;
      #(bit_ns * 1ns);
   endtask

   // Every output pulse must match the head of the expectation queue.
   always @(negedge clk) begin : mon
      exp_t       e;
      logic [1:0] exp_kind;
      if (rst_n && (rx_valid || frame_err)) begin
         exp_kind = 2'b00;
         if (exp_q.size() != 0) begin
            e        = exp_q.pop_front();
            exp_kind = e.is_err ? 2'b10 : 2'b01;
            if (!e.is_err) last_good = e.data;
         end
         chk("pulse_kind", {30'd0, frame_err, rx_valid}, {30'd0, exp_kind});
         chk("pulse_data", {24'd0, rx_data}, {24'd0, last_good});
      end
   end

   initial begin : stim
      int unsigned busy_cnt;
      int unsigned bit_ns;
      logic [7:0]  b;
      logic [7:0]  v;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_data", {24'd0, rx_data}, 32'h00);
      chk("rst_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single frame
      send_frame(8'hA5, 1'b1, 100);
      #100ns;
      chk("t1_data", {24'd0, rx_data}, 32'hA5);
      chk("t1_busy", {31'd0, busy}, 32'd0);
      chk("t1_qempty", exp_q.size(), 32'd0);

      // Back-to-back, no idle gap
      send_frame(8'h00, 1'b1, 100);
      send_frame(8'hFF, 1'b1, 100);
      #100ns;
      chk("t2_data", {24'd0, rx_data}, 32'hFF);
      chk("t2_qempty", exp_q.size(), 32'd0);

      // 3-clk glitch on an idle line
      @(negedge clk);
      rx_i = 1'b0;
      repeat (3) @(negedge clk);
      rx_i = 1'b1;
      busy_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      chk("glitch_busy_le5", {31'd0, busy_cnt <= 5}, 32'd1);
      chk("glitch_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
      chk("glitch_idle", {31'd0, busy}, 32'd0);

      // Framing error followed by a held-low line
      send_frame(8'h3C, 1'b0, 100);
      repeat (50) @(negedge clk);
      chk("break_busy", {31'd0, busy}, 32'd1);
      chk("break_data", {24'd0, rx_data}, {24'd0, last_good});
      rx_i = 1'b1;
      #200ns;
      chk("break_exit", {31'd0, busy}, 32'd0);
      send_frame(8'h11, 1'b1, 100);
      #100ns;
      chk("t4_data", {24'd0, rx_data}, 32'h11);

      // Reset during bit 4 of 8'h5A
      b = 8'h5A;
      rx_i = 1'b0;
      #100ns;
      for (int i = 0; i < 4; i++) begin
         rx_i = b[i];
         #100ns;
      end
      rx_i = b[4];
      #50ns;
      @(negedge clk);
      rst_n = 1'b0;
      rx_i  = 1'b1;
      @(negedge clk);
      chk("mid_rst_data", {24'd0, rx_data}, 32'h00);
      chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
      chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      last_good = 8'h00;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      send_frame(8'h5A, 1'b1, 100);
      #100ns;
      chk("t5_data", {24'd0, rx_data}, 32'h5A);

      // Baud skew +/-3%
      send_frame(8'hC3, 1'b1, 103);
      #200ns;
      chk("skew_slow", {24'd0, rx_data}, 32'hC3);
      send_frame(8'h3C, 1'b1, 100);
      send_frame(8'hC3, 1'b1, 97);
      #200ns;
      chk("skew_fast", {24'd0, rx_data}, 32'hC3);

      // Randomized frames, skew and occasional framing errors
      for (int n = 0; n < 20; n++) begin
         v      = 8'($urandom);
         bit_ns = 97 + $urandom_range(0, 6);
         if ($urandom_range(0, 5) == 0) begin
            send_frame(v, 1'b0, bit_ns);
            repeat ($urandom_range(10, 60)) @(negedge clk);
            rx_i = 1'b1;
            #150ns;
         end else begin
            send_frame(v, 1'b1, bit_ns);
            #($urandom_range(0, 150) * 1ns);
         end
      end

      // Bounded drain of outstanding expectations
      for (int c = 0; c < 300; c++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("final_qempty", exp_q.size(), 32'd0);
      chk("final_data", {24'd0, rx_data}, {24'd0, last_good});
      chk("final_busy", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
